// File: rtl/data_mem_responder_if.sv
// Per-thread data-memory valid/ready channels between the compute core (master)
// and the data-memory responder (slave).
interface data_mem_responder_if #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4
);
  logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

  modport master (
    output consumer_read_valid, consumer_read_address,
    output consumer_write_valid, consumer_write_address, consumer_write_data,
    input  consumer_read_ready, consumer_read_data, consumer_write_ready
  );

  modport slave (
    input  consumer_read_valid, consumer_read_address,
    input  consumer_write_valid, consumer_write_address, consumer_write_data,
    output consumer_read_ready, consumer_read_data, consumer_write_ready
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-port data RAM shared round-robin by per-thread LSU channels; each access
// is answered with a registered ready (and read data) after a fixed latency.
module data_mem_responder #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int LATENCY       = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  input  logic                 load_valid,
  input  logic [ADDR_BITS-1:0] load_address,
  input  logic [DATA_BITS-1:0] load_data,
  output logic                 busy
);
  localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RELAY = 2'd2
  } state_e;

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  state_e                                  state_q [NUM_CONSUMERS];
  state_e                                  state_d [NUM_CONSUMERS];
  logic [CNT_W-1:0]                        cnt_q   [NUM_CONSUMERS];
  logic [CNT_W-1:0]                        cnt_d   [NUM_CONSUMERS];
  logic [NUM_CONSUMERS-1:0]                is_read_q, is_read_d;
  logic [NUM_CONSUMERS-1:0]                rd_ready_q, rd_ready_d;
  logic [NUM_CONSUMERS-1:0]                wr_ready_q, wr_ready_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rdata_q, rdata_d;
  logic [PTR_W-1:0]                        rr_ptr_q, rr_ptr_d;
  logic                                    busy_q, busy_d;

  logic [NUM_CONSUMERS-1:0] rv, wv, req;
  logic [PTR_W-1:0]         grant_idx, scan_idx;
  logic [PTR_W:0]           scan_sum;
  logic                     grant_found;
  logic                     mem_we;
  logic [ADDR_BITS-1:0]     mem_waddr;
  logic [DATA_BITS-1:0]     mem_wdata;

  assign rv = bus.consumer_read_valid;
  assign wv = bus.consumer_write_valid;

  // Next-state: per-channel FSM, round-robin arbiter and the single RAM access.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_read_d  = is_read_q;
    rd_ready_d = rd_ready_q;
    wr_ready_d = wr_ready_q;
    rdata_d    = rdata_q;
    rr_ptr_d   = rr_ptr_q;
    busy_d     = 1'b0;
    req        = '0;
    grant_found = 1'b0;
    grant_idx  = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    mem_we     = load_valid;
    mem_waddr  = load_address;
    mem_wdata  = load_data;

    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      req[i] = (state_q[i] == ST_IDLE) && (rv[i] || wv[i]);
      case (state_q[i])
        ST_IDLE: begin
          state_d[i] = ST_IDLE;
        end
        ST_WAIT: begin
          if (cnt_q[i] <= CNT_W'(1)) begin
            state_d[i]    = ST_RELAY;
            cnt_d[i]      = '0;
            rd_ready_d[i] = is_read_q[i];
            wr_ready_d[i] = !is_read_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        ST_RELAY: begin
          // Only the valid of the access being answered closes the handshake.
          if (!(is_read_q[i] ? rv[i] : wv[i])) begin
            state_d[i]    = ST_IDLE;
            rd_ready_d[i] = 1'b0;
            wr_ready_d[i] = 1'b0;
          end else begin
            state_d[i] = ST_RELAY;
          end
        end
        default: begin
          state_d[i]    = ST_IDLE;
          rd_ready_d[i] = 1'b0;
          wr_ready_d[i] = 1'b0;
        end
      endcase
    end

    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      scan_idx = (scan_sum >= (PTR_W+1)'(NUM_CONSUMERS)) ?
                 PTR_W'(scan_sum - (PTR_W+1)'(NUM_CONSUMERS)) : scan_sum[PTR_W-1:0];
      if (!grant_found && !load_valid && req[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end else begin
        grant_found = grant_found;
      end
    end

    if (grant_found) begin
      rr_ptr_d = (grant_idx == PTR_W'(NUM_CONSUMERS - 1)) ? '0 : grant_idx + PTR_W'(1);
      is_read_d[grant_idx] = rv[grant_idx];
      if (rv[grant_idx]) begin
        rdata_d[grant_idx] = mem[bus.consumer_read_address[grant_idx]];
      end else begin
        mem_we    = 1'b1;
        mem_waddr = bus.consumer_write_address[grant_idx];
        mem_wdata = bus.consumer_write_data[grant_idx];
      end
      if (LATENCY == 1) begin
        state_d[grant_idx]    = ST_RELAY;
        rd_ready_d[grant_idx] = rv[grant_idx];
        wr_ready_d[grant_idx] = !rv[grant_idx];
      end else begin
        state_d[grant_idx] = ST_WAIT;
        cnt_d[grant_idx]   = CNT_W'(LATENCY - 1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end

    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      if (state_d[i] != ST_IDLE) begin
        busy_d = 1'b1;
      end else begin
        busy_d = busy_d;
      end
    end
  end

  // Channel state, arbiter pointer and registered responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      is_read_q  <= '0;
      rd_ready_q <= '0;
      wr_ready_q <= '0;
      rdata_q    <= '0;
      rr_ptr_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_read_q  <= is_read_d;
      rd_ready_q <= rd_ready_d;
      wr_ready_q <= wr_ready_d;
      rdata_q    <= rdata_d;
      rr_ptr_q   <= rr_ptr_d;
      busy_q     <= busy_d;
    end
  end

  // Backing store is deliberately not reset so preloaded contents survive.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.consumer_read_ready  = rd_ready_q;
  assign bus.consumer_write_ready = wr_ready_q;
  assign bus.consumer_read_data   = rdata_q;
  assign busy                     = busy_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: drivers push expected responses per
// channel, a negedge monitor pops them whenever a ready rises.
module tb_data_mem_responder;
  localparam int N = 4;

  typedef struct {
    bit         rd;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load_valid = 1'b0;
  logic [7:0] load_address = 8'd0;
  logic [7:0] load_data = 8'd0;
  logic busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] ref_mem [256];
  exp_t       exp_q [N][$];
  int         rise_log [$];
  int         rise_cyc [N];
  logic [N-1:0] prev_rd = '0;
  logic [N-1:0] prev_wr = '0;

  data_mem_responder_if #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(N)) bus ();

  data_mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(N), .LATENCY(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .load_valid   (load_valid),
    .load_address (load_address),
    .load_data    (load_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic bit rdy(input int ch, input bit rd);
    return rd ? bus.consumer_read_ready[ch] : bus.consumer_write_ready[ch];
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pop_check(input int ch, input bit rd, input logic [7:0] data);
    exp_t e;
    checks++;
    if (exp_q[ch].size() == 0) begin
      failures++;
      $display("FAIL unexpected_ready ch=%0d rd=%0d: actual=response required=none", ch, rd);
    end else begin
      e = exp_q[ch].pop_front();
      if (e.rd != rd || (rd && data !== e.data)) begin
        failures++;
        $display("FAIL response ch=%0d: actual rd=%0d data=%0h required rd=%0d data=%0h",
                 ch, rd, data, e.rd, e.data);
      end
    end
  endtask

  // Monitor: every rising ready must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (bus.consumer_read_ready[c] && !prev_rd[c]) begin
        pop_check(c, 1'b1, bus.consumer_read_data[c]);
        rise_log.push_back(c);
        rise_cyc[c] = cyc;
      end
      if (bus.consumer_write_ready[c] && !prev_wr[c]) begin
        pop_check(c, 1'b0, 8'd0);
        rise_log.push_back(c);
      end
    end
    prev_rd = bus.consumer_read_ready;
    prev_wr = bus.consumer_write_ready;
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    load_valid = 1'b1;
    load_address = a;
    load_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic wait_rdy(input int ch, input bit rd, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rdy(ch, rd) && lat < 100);
    checks++;
    if (!rdy(ch, rd)) begin
      failures++;
      $display("FAIL ready_timeout ch=%0d rd=%0d: actual=0 required=1", ch, rd);
    end
  endtask

  // One complete four-phase transaction; called at a negedge.
  task automatic txn(input int ch, input bit rd, input logic [7:0] a, input logic [7:0] d,
                     input int hold, output int lat);
    exp_t e;
    e.rd = rd;
    if (rd) begin
      e.data = ref_mem[a];
      bus.consumer_read_address[ch] = a;
      bus.consumer_read_valid[ch] = 1'b1;
    end else begin
      e.data = d;
      ref_mem[a] = d;
      bus.consumer_write_address[ch] = a;
      bus.consumer_write_data[ch] = d;
      bus.consumer_write_valid[ch] = 1'b1;
    end
    exp_q[ch].push_back(e);
    wait_rdy(ch, rd, lat);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (!rdy(ch, rd) || (rd && bus.consumer_read_data[ch] !== e.data)) begin
        failures++;
        $display("FAIL hold_stable ch=%0d: actual ready=%0d data=%0h required ready=1 data=%0h",
                 ch, rdy(ch, rd), bus.consumer_read_data[ch], e.data);
      end
    end
    if (rd) bus.consumer_read_valid[ch] = 1'b0;
    else    bus.consumer_write_valid[ch] = 1'b0;
    @(negedge clk);
    check($sformatf("ready_release_ch%0d", ch), int'(rdy(ch, rd)), 0);
  endtask

  task automatic rand_worker(input int ch);
    int lat;
    logic [7:0] a;
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = {2'(ch), 6'($urandom)};
      txn(ch, 1'($urandom_range(0, 1)), a, 8'($urandom), $urandom_range(0, 2), lat);
    end
  endtask

  initial begin
    int l0, l1, l2, l3, lat;
    exp_t e;
    bus.consumer_read_valid = '0;
    bus.consumer_read_address = '0;
    bus.consumer_write_valid = '0;
    bus.consumer_write_address = '0;
    bus.consumer_write_data = '0;

    repeat (3) @(negedge clk);
    check("reset_read_ready", int'(bus.consumer_read_ready), 0);
    check("reset_write_ready", int'(bus.consumer_write_ready), 0);
    check("reset_read_data", int'(bus.consumer_read_data), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b1;

    for (int a = 0; a < 256; a++) preload(8'(a), 8'($urandom));
    preload(8'h10, 8'hAB);

    // All four channels at once from rr_ptr=0: served 0,1,2,3 on consecutive edges.
    @(negedge clk);
    fork
      txn(0, 1'b1, 8'h11, 8'h00, 0, l0);
      txn(1, 1'b1, 8'h12, 8'h00, 0, l1);
      txn(2, 1'b1, 8'h13, 8'h00, 0, l2);
      txn(3, 1'b1, 8'h14, 8'h00, 0, l3);
    join
    check("rr_lat0", l0, 2);
    check("rr_lat1", l1, 3);
    check("rr_lat2", l2, 4);
    check("rr_lat3", l3, 5);
    check("rr_order1", rise_cyc[1] - rise_cyc[0], 1);
    check("rr_order3", rise_cyc[3] - rise_cyc[2], 1);

    // Uncontended read with extended hold.
    txn(0, 1'b1, 8'h10, 8'h00, 3, lat);
    check("uncontended_latency", lat, 2);

    // ch0 and ch2 hammering: service must alternate.
    rise_log.delete();
    fork
      for (int n = 0; n < 4; n++) txn(0, 1'b1, 8'h50 + 8'(n), 8'h00, 0, l0);
      for (int n = 0; n < 4; n++) txn(2, 1'b1, 8'h60 + 8'(n), 8'h00, 0, l2);
    join
    check("alt_count", rise_log.size(), 8);
    for (int n = 1; n < rise_log.size(); n++)
      check($sformatf("alt_switch%0d", n), int'(rise_log[n] != rise_log[n-1]), 1);

    // Write on ch1 then read it back on ch3.
    txn(1, 1'b0, 8'h20, 8'h5A, 0, lat);
    txn(3, 1'b1, 8'h20, 8'h00, 0, lat);

    // Read and write raised together: read first, then write.
    e.rd = 1'b1; e.data = ref_mem[8'h30]; exp_q[0].push_back(e);
    e.rd = 1'b0; e.data = 8'h77; exp_q[0].push_back(e);
    ref_mem[8'h31] = 8'h77;
    bus.consumer_read_address[0] = 8'h30;
    bus.consumer_write_address[0] = 8'h31;
    bus.consumer_write_data[0] = 8'h77;
    bus.consumer_read_valid[0] = 1'b1;
    bus.consumer_write_valid[0] = 1'b1;
    wait_rdy(0, 1'b1, lat);
    check("dual_write_not_first", int'(bus.consumer_write_ready[0]), 0);
    bus.consumer_read_valid[0] = 1'b0;
    wait_rdy(0, 1'b0, lat);
    bus.consumer_write_valid[0] = 1'b0;
    @(negedge clk);
    check("dual_write_release", int'(bus.consumer_write_ready[0]), 0);
    txn(0, 1'b1, 8'h31, 8'h00, 0, lat);

    // Valid dropped during the wait: access completes, ready pulses once.
    e.rd = 1'b0; e.data = 8'h3C; exp_q[3].push_back(e);
    ref_mem[8'h45] = 8'h3C;
    bus.consumer_write_address[3] = 8'h45;
    bus.consumer_write_data[3] = 8'h3C;
    bus.consumer_write_valid[3] = 1'b1;
    @(negedge clk);
    bus.consumer_write_valid[3] = 1'b0;
    @(negedge clk);
    check("early_drop_pulse", int'(bus.consumer_write_ready[3]), 1);
    @(negedge clk);
    check("early_drop_pulse_end", int'(bus.consumer_write_ready[3]), 0);
    txn(2, 1'b1, 8'h45, 8'h00, 0, lat);

    // Reset while ch0 is relaying and ch2 is waiting.
    bus.consumer_read_address[0] = 8'h70;
    bus.consumer_read_valid[0] = 1'b1;
    e.rd = 1'b1; e.data = ref_mem[8'h70]; exp_q[0].push_back(e);
    wait_rdy(0, 1'b1, lat);
    bus.consumer_read_address[2] = 8'h71;
    bus.consumer_read_valid[2] = 1'b1;
    e.rd = 1'b1; e.data = ref_mem[8'h71]; exp_q[2].push_back(e);
    @(negedge clk);
    check("pre_reset_busy", int'(busy), 1);
    reset = 1'b0;
    #1;
    check("async_reset_read_ready", int'(bus.consumer_read_ready), 0);
    check("async_reset_busy", int'(busy), 0);
    exp_q[2].delete();
    bus.consumer_read_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    txn(3, 1'b1, 8'h20, 8'h00, 0, lat);

    // Preload in the same cycle as ch1's request delays its grant by one.
    load_valid = 1'b1;
    load_address = 8'h40;
    load_data = 8'hC3;
    ref_mem[8'h40] = 8'hC3;
    fork
      txn(1, 1'b1, 8'h40, 8'h00, 0, lat);
      begin @(negedge clk); load_valid = 1'b0; end
    join
    check("load_stall_latency", lat, 3);

    // Randomized traffic; each channel owns a disjoint quarter of the address space.
    fork
      rand_worker(0);
      rand_worker(1);
      rand_worker(2);
      rand_worker(3);
    join

    repeat (5) @(negedge clk);
    for (int c = 0; c < N; c++)
      check($sformatf("drained_ch%0d", c), exp_q[c].size(), 0);
    check("idle_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
